adc_spi_target: RTL and testbench

ADC_SPI_TARGET -- requirements
Module: adc_spi_target

---
 rtl/digitizer_spi_pkg.sv | 17 +
 rtl/spi_sync3.sv | 29 ++
 rtl/adc_spi_target.sv | 188 ++++++++++++++++++
 tb/tb_adc_spi_target.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/digitizer_spi_pkg.sv
// Shared frame geometry and FSM state encoding for the digitizer SPI register target.
package digitizer_spi_pkg;

  localparam int INSTR_BITS = 16;
  localparam int DATA_BITS  = 8;
  localparam int ADDR_W     = 13;
  localparam int FRAME_BITS = INSTR_BITS + DATA_BITS;

  typedef enum logic [2:0] {
    IDLE,
    INSTR,
    WDATA,
    RDATA,
    DONE
  } spi_state_e;

endpackage

// File: rtl/spi_sync3.sv
// Two-flop synchronizer plus one history flop, so edges can be taken from the last two stages.
module spi_sync3 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic sync_o,
  output logic hist_o
);

  logic meta_q, sync_q, hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      hist_q <= RST_VAL;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      hist_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign hist_o = hist_q;

endmodule

// File: rtl/adc_spi_target.sv
// SPI mode-0 register target for an llspi-style initiator: 16-bit instruction, 8 data bits,
// oversampled in the clk domain with registered edge pulses.
module adc_spi_target
  import digitizer_spi_pkg::*;
#(
  parameter int         NREG    = 16,
  parameter logic [7:0] CHIP_ID = 8'h8B
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sclk,
  input  logic                csb,
  input  logic                sdio_in,
  output logic                sdo,
  output logic                sdo_oe,
  output logic                wr_stb,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [7:0]          wr_data,
  output logic [8*NREG-1:0]   regs_flat,
  output logic                xfer_err
);

  localparam int SHIFT_W = ADDR_W + DATA_BITS;
  localparam int IDX_W   = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [4:0] CNT_INSTR = 5'(INSTR_BITS);
  localparam logic [4:0] CNT_FRAME = 5'(FRAME_BITS);
  localparam logic [ADDR_W-1:0] NREG_A  = ADDR_W'(NREG);
  localparam logic [ADDR_W-1:0] ID_ADDR = ADDR_W'(1);

  logic sclk_s, sclk_h, csb_s, csb_h, sdio_s, sdio_h_unused;

  spi_sync3 #(.RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst_n(rst_n), .din(sclk),
                                           .sync_o(sclk_s), .hist_o(sclk_h));
  spi_sync3 #(.RST_VAL(1'b1)) u_sync_csb  (.clk(clk), .rst_n(rst_n), .din(csb),
                                           .sync_o(csb_s), .hist_o(csb_h));
  spi_sync3 #(.RST_VAL(1'b0)) u_sync_sdio (.clk(clk), .rst_n(rst_n), .din(sdio_in),
                                           .sync_o(sdio_s), .hist_o(sdio_h_unused));

  logic sclk_rise_d, sclk_rise_q, sclk_fall_d, sclk_fall_q;
  logic csb_rise_d, csb_rise_q, csb_fall_d, csb_fall_q;
  logic sdio_bit_d, sdio_bit_q;

  spi_state_e          state_d, state_q;
  logic [4:0]          cnt_d, cnt_q;
  logic [SHIFT_W-1:0]  shift_d, shift_q;
  logic [7:0]          rdata_d, rdata_q;
  logic                sdo_d, sdo_q, sdo_oe_d, sdo_oe_q;
  logic                wr_stb_d, wr_stb_q, xfer_err_d, xfer_err_q;
  logic [ADDR_W-1:0]   wr_addr_d, wr_addr_q;
  logic [7:0]          wr_data_d, wr_data_q;
  logic [7:0]          regs_d [NREG];
  logic [7:0]          regs_q [NREG];

  logic [7:0]          rd_val;
  logic [ADDR_W-1:0]   cm_addr;
  logic [7:0]          cm_data;

  always_comb begin
    sclk_rise_d = sclk_s & ~sclk_h;
    sclk_fall_d = ~sclk_s & sclk_h;
    csb_rise_d  = csb_s & ~csb_h;
    csb_fall_d  = ~csb_s & csb_h;
    sdio_bit_d  = sdio_s;
  end

  // Instruction view of the shifter is valid at the INSTR exit, frame view at the commit.
  always_comb begin
    rd_val  = 8'h00;
    cm_addr = shift_q[SHIFT_W-1:DATA_BITS];
    cm_data = shift_q[DATA_BITS-1:0];
    if (shift_q[ADDR_W-1:0] == ID_ADDR) begin
      rd_val = CHIP_ID;
    end else if (shift_q[ADDR_W-1:0] < NREG_A) begin
      rd_val = regs_q[shift_q[IDX_W-1:0]];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    rdata_d    = rdata_q;
    sdo_d      = sdo_q;
    sdo_oe_d   = sdo_oe_q;
    wr_stb_d   = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    xfer_err_d = xfer_err_q;
    regs_d     = regs_q;

    if (sclk_rise_q && (state_q == INSTR || state_q == WDATA || state_q == RDATA)) begin
      if (cnt_q != CNT_FRAME) cnt_d = cnt_q + 5'd1;
      if (state_q != RDATA) shift_d = {shift_q[SHIFT_W-2:0], sdio_bit_q};
    end

    // csb release outranks every other event, including a same-cycle final sclk edge.
    if (csb_rise_q && state_q != IDLE) begin
      state_d  = IDLE;
      sdo_d    = 1'b0;
      sdo_oe_d = 1'b0;
      if (state_q != DONE) xfer_err_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (csb_fall_q) begin
            state_d    = INSTR;
            cnt_d      = 5'd0;
            xfer_err_d = 1'b0;
          end
        end
        INSTR: begin
          if (cnt_q == CNT_INSTR) begin
            state_d = shift_q[INSTR_BITS-1] ? RDATA : WDATA;
            rdata_d = rd_val;
          end
        end
        WDATA: begin
          if (cnt_q == CNT_FRAME) begin
            state_d   = DONE;
            wr_stb_d  = 1'b1;
            wr_addr_d = cm_addr;
            wr_data_d = cm_data;
            if (cm_addr < NREG_A && cm_addr != ID_ADDR) regs_d[cm_addr[IDX_W-1:0]] = cm_data;
          end
        end
        RDATA: begin
          if (sclk_fall_q && cnt_q < CNT_FRAME) begin
            sdo_oe_d = 1'b1;
            sdo_d    = rdata_q[7];
            rdata_d  = {rdata_q[6:0], 1'b0};
          end
          if (cnt_q == CNT_FRAME) state_d = DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_rise_q <= 1'b0;
      sclk_fall_q <= 1'b0;
      csb_rise_q  <= 1'b0;
      csb_fall_q  <= 1'b0;
      sdio_bit_q  <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= 5'd0;
      shift_q     <= '0;
      rdata_q     <= 8'h00;
      sdo_q       <= 1'b0;
      sdo_oe_q    <= 1'b0;
      wr_stb_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 8'h00;
      xfer_err_q  <= 1'b0;
      regs_q      <= '{default: 8'h00};
    end else begin
      sclk_rise_q <= sclk_rise_d;
      sclk_fall_q <= sclk_fall_d;
      csb_rise_q  <= csb_rise_d;
      csb_fall_q  <= csb_fall_d;
      sdio_bit_q  <= sdio_bit_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      rdata_q     <= rdata_d;
      sdo_q       <= sdo_d;
      sdo_oe_q    <= sdo_oe_d;
      wr_stb_q    <= wr_stb_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      xfer_err_q  <= xfer_err_d;
      regs_q      <= regs_d;
    end
  end

  for (genvar k = 0; k < NREG; k++) begin : g_flat
    assign regs_flat[8*k +: 8] = regs_q[k];
  end

  assign sdo      = sdo_q;
  assign sdo_oe   = sdo_oe_q;
  assign wr_stb   = wr_stb_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign xfer_err = xfer_err_q;

endmodule

// File: tb/tb_adc_spi_target.sv
// Randomized scoreboard bench for adc_spi_target: frames are driven as an SPI initiator,
// expected commits/readbacks are queued from a register-array model and popped by monitors.
module tb_adc_spi_target;

  localparam int         NREG    = 16;
  localparam logic [7:0] CHIP_ID = 8'h8B;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk = 1'b0;
  logic csb = 1'b1;
  logic sdio_in = 1'b0;
  logic sdo, sdo_oe, wr_stb, xfer_err;
  logic [12:0] wr_addr;
  logic [7:0] wr_data;
  logic [8*NREG-1:0] regs_flat;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [12:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t        exp_wr_q[$];
  logic [7:0] exp_rd_q[$];
  logic [7:0] model_regs [NREG];
  wr_t        wr_exp;
  logic [7:0] rd_bits;
  int         rd_cnt = 0;
  int         lat_k, lat_hit;

  adc_spi_target #(.NREG(NREG), .CHIP_ID(CHIP_ID)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .csb(csb), .sdio_in(sdio_in),
    .sdo(sdo), .sdo_oe(sdo_oe), .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
    .regs_flat(regs_flat), .xfer_err(xfer_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [8*NREG-1:0] actual,
                             input logic [8*NREG-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [7:0] model_read(input logic [12:0] a);
    if (a == 13'd1) return CHIP_ID;
    if (a < NREG) return model_regs[int'(a)];
    return 8'h00;
  endfunction

  function automatic logic [8*NREG-1:0] model_flat();
    logic [8*NREG-1:0] v;
    for (int k = 0; k < NREG; k++) v[8*k +: 8] = model_regs[k];
    return v;
  endfunction

  // Every strobe must match the oldest committed write the model expects.
  always @(negedge clk) begin
    if (wr_stb) begin
      if (exp_wr_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL wr_unexpected: got strobe addr=%0h data=%0h, expected none", wr_addr, wr_data);
      end else begin
        wr_exp = exp_wr_q.pop_front();
        checkOutput("wr_addr", wr_addr, wr_exp.addr);
        checkOutput("wr_data", wr_data, wr_exp.data);
      end
    end
  end

  // Readback bits are captured where the initiator would sample them: sclk rising edges.
  always @(posedge sclk or posedge csb) begin
    if (csb) begin
      rd_cnt = 0;
    end else if (sdo_oe && rd_cnt < 8) begin
      rd_bits = {rd_bits[6:0], sdo};
      rd_cnt++;
      if (rd_cnt == 8) begin
        if (exp_rd_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL rd_unexpected: got byte %0h, expected none", rd_bits);
        end else begin
          checkOutput("rd_data", rd_bits, exp_rd_q.pop_front());
        end
      end
    end
  end

  task automatic half_period(input bit watch);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (watch) begin
        lat_k++;
        if (wr_stb && lat_hit == 0) lat_hit = lat_k;
      end
    end
  endtask

  task automatic applyStimulus(input bit rw, input logic [12:0] addr, input logic [7:0] data,
                               input int nbits, input int extra, input bit rst_mid);
    logic [23:0] frame;
    bit full;
    frame = {rw, 2'b00, addr, data};
    full  = (nbits == 24) && !rst_mid;
    if (full && !rw) begin
      exp_wr_q.push_back('{addr: addr, data: data});
      if (addr < NREG && addr != 13'd1) model_regs[int'(addr)] = data;
    end
    if (full && rw) exp_rd_q.push_back(model_read(addr));

    @(negedge clk);
    csb = 1'b0;
    half_period(0);
    half_period(0);
    checkOutput("xfer_err_cleared", xfer_err, 0);
    lat_k = 0;
    lat_hit = 0;
    for (int i = 0; i < nbits; i++) begin
      sdio_in = (rw && i >= 16) ? 1'b0 : frame[23-i];
      half_period(0);
      if (rw && i == 15) checkOutput("oe_instr_phase", sdo_oe, 0);
      if (rw && i == 16) checkOutput("oe_after_fall16", sdo_oe, 1);
      sclk = 1'b1;
      half_period(full && !rw && i == 23);
      sclk = 1'b0;
    end
    half_period(full && !rw);
    for (int e = 0; e < extra; e++) begin
      sclk = 1'b1;
      half_period(0);
      sclk = 1'b0;
      half_period(0);
    end

    if (rst_mid) begin
      rst_n = 1'b0;
      @(negedge clk);
      csb = 1'b1;
      @(negedge clk);
      for (int k = 0; k < NREG; k++) model_regs[k] = 8'h00;
      checkOutput("rst_regs", regs_flat, model_flat());
      checkOutput("rst_sdo_oe", sdo_oe, 0);
      checkOutput("rst_sdo", sdo, 0);
      checkOutput("rst_wr_stb", wr_stb, 0);
      checkOutput("rst_wr_addr", wr_addr, 0);
      checkOutput("rst_wr_data", wr_data, 0);
      checkOutput("rst_xfer_err", xfer_err, 0);
      rst_n = 1'b1;
      half_period(0);
      half_period(0);
    end else begin
      if (full && !rw) checkOutput("wr_latency", lat_hit, 5);
      if (full && rw) checkOutput("oe_before_csb_rise", sdo_oe, 1);
      csb = 1'b1;
      half_period(0);
      half_period(0);
      checkOutput("oe_after_csb_rise", sdo_oe, 0);
      checkOutput("xfer_err", xfer_err, full ? 0 : 1);
      checkOutput("regs_flat", regs_flat, model_flat());
    end
  endtask

  initial begin
    logic [12:0] a;
    logic [7:0] d;
    int r;
    for (int k = 0; k < NREG; k++) model_regs[k] = 8'h00;

    repeat (3) @(negedge clk);
    checkOutput("reset_sdo", sdo, 0);
    checkOutput("reset_sdo_oe", sdo_oe, 0);
    checkOutput("reset_wr_stb", wr_stb, 0);
    checkOutput("reset_wr_addr", wr_addr, 0);
    checkOutput("reset_wr_data", wr_data, 0);
    checkOutput("reset_xfer_err", xfer_err, 0);
    checkOutput("reset_regs", regs_flat, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    applyStimulus(0, 13'h005, 8'hA7, 24, 0, 0);
    checkOutput("reg5", regs_flat[47:40], 8'hA7);
    applyStimulus(1, 13'h001, 8'h00, 24, 0, 0);
    applyStimulus(0, 13'h001, 8'h55, 24, 0, 0);
    applyStimulus(1, 13'h001, 8'h00, 24, 0, 0);
    applyStimulus(0, 13'h003, 8'($urandom), 20, 0, 0);
    applyStimulus(1, 13'h005, 8'h00, 24, 0, 0);
    applyStimulus(0, 13'h1FFF, 8'hFF, 24, 0, 0);
    applyStimulus(1, 13'h1FFF, 8'h00, 24, 0, 0);

    for (int n = 0; n < 14; n++) begin
      r = $urandom_range(0, 19);
      a = (r <= NREG + 1) ? 13'(r) : 13'h1FFF;
      d = 8'($urandom);
      applyStimulus(1'($urandom_range(0, 1)), a, d, 24, 0, 0);
    end

    applyStimulus(0, 13'h002, 8'h3C, 24, 8, 0);
    checkOutput("reg2_before_reset", regs_flat[23:16], 8'h3C);
    applyStimulus(0, 13'($urandom_range(0, NREG - 1)), 8'($urandom), 10, 0, 1);

    d = 8'($urandom);
    applyStimulus(0, 13'h007, d, 24, 0, 0);
    applyStimulus(1, 13'h007, 8'h00, 24, 0, 0);

    checkOutput("wr_queue_drained", exp_wr_q.size(), 0);
    checkOutput("rd_queue_drained", exp_rd_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
